// File: rtl/multicycle_control_unit.sv
// Control FSM for the multicycle RV32 datapath.
// Moore-decoded enables, selects and ALU control, plus an illegal flag and a retire counter.
module multicycle_control_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    output logic             mem_write,
    output logic             reg_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             instruction_or_data,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic             illegal,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t      state;
    state_t      state_next;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic        op5;
    logic        f7b5;

    logic        pc_update;
    logic        branch;
    logic        ir_write_s;
    logic        reg_write_s;
    logic        mem_write_s;
    logic [1:0]  alu_op;
    logic        retire_now;

    logic        unused_instr;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign op5    = instr[5];
    assign f7b5   = instr[30];

    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state Moore outputs.
    always_comb begin
        state_next          = state;
        pc_update           = 1'b0;
        branch              = 1'b0;
        ir_write_s          = 1'b0;
        reg_write_s         = 1'b0;
        mem_write_s         = 1'b0;
        instruction_or_data = 1'b0;
        result_src          = 2'b00;
        alu_src_a           = 2'b00;
        alu_src_b           = 2'b00;
        alu_op              = 2'b00;
        unique case (state)
            FETCH: begin
                ir_write_s = 1'b1;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_update  = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b10;
                unique case (opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECR;
                    OP_I:         state_next = EXECI;
                    OP_BR:        state_next = (f3 == 3'b000) ? BEQ : ILLEGAL;
                    OP_JAL:       state_next = JAL;
                    default:      state_next = ILLEGAL;
                endcase
            end
            MEMADR: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                state_next = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                instruction_or_data = 1'b1;
                state_next          = MEMWB;
            end
            MEMWB: begin
                result_src  = 2'b01;
                reg_write_s = 1'b1;
                state_next  = FETCH;
            end
            MEMWRITE: begin
                instruction_or_data = 1'b1;
                mem_write_s         = 1'b1;
                state_next          = FETCH;
            end
            EXECR: begin
                alu_src_a  = 2'b01;
                alu_op     = 2'b10;
                state_next = ALUWB;
            end
            EXECI: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                alu_op     = 2'b10;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_write_s = 1'b1;
                state_next  = FETCH;
            end
            BEQ: begin
                alu_src_a  = 2'b01;
                alu_op     = 2'b01;
                branch     = 1'b1;
                state_next = FETCH;
            end
            JAL: begin
                alu_src_b  = 2'b01;
                pc_update  = 1'b1;
                state_next = ALUWB;
            end
            ILLEGAL: begin
                state_next = ILLEGAL;
            end
            default: begin
                state_next = ILLEGAL;
            end
        endcase
    end

    // ALU decoder: funct fields only matter for alu_op=10.
    always_comb begin
        alu_control = 3'b000;
        unique case (alu_op)
            2'b01: alu_control = 3'b001;
            2'b10: begin
                unique case (f3)
                    3'b000:  alu_control = (op5 & f7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    // Enables are held low while reset is asserted.
    assign ir_write  = ir_write_s & ~reset;
    assign reg_write = reg_write_s & ~reset;
    assign mem_write = mem_write_s & ~reset;
    assign pc_write  = (pc_update | (branch & zero)) & ~reset;
    assign state_dbg = state;

    assign retire_now = (state == MEMWB) || (state == MEMWRITE) ||
                        (state == ALUWB) || (state == BEQ);

    // Sticky illegal flag, set on entry to ILLEGAL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal <= 1'b0;
        end else if (state_next == ILLEGAL) begin
            illegal <= 1'b1;
        end
    end

    // Retired counter bumps on the edge leaving a final state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired <= '0;
        end else if (retire_now) begin
            retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit.
// Walks each instruction class through the FSM and checks outputs per state.
module tb_multicycle_control_unit;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        mem_write;
    logic        reg_write;
    logic        ir_write;
    logic        pc_write;
    logic        instruction_or_data;
    logic [1:0]  result_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_control;
    logic        illegal;
    logic [3:0]  state_dbg;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    multicycle_control_unit #(.CNT_W(32)) dut (
        .clk                 (clk),
        .reset               (reset),
        .instr               (instr),
        .zero                (zero),
        .mem_write           (mem_write),
        .reg_write           (reg_write),
        .ir_write            (ir_write),
        .pc_write            (pc_write),
        .instruction_or_data (instruction_or_data),
        .result_src          (result_src),
        .alu_src_a           (alu_src_a),
        .alu_src_b           (alu_src_b),
        .alu_control         (alu_control),
        .illegal             (illegal),
        .state_dbg           (state_dbg),
        .retired             (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] enables();
        return {mem_write, reg_write, ir_write, pc_write};
    endfunction

    initial begin
        reset = 1'b1;
        instr = 32'h00402083;
        zero  = 1'b0;

        // reset held 3 cycles
        step();
        chk("rst_en_c1", 32'(enables()), 32'h0);
        chk("rst_st_c1", 32'(state_dbg), 32'd0);
        step();
        step();
        chk("rst_en_c3", 32'(enables()), 32'h0);
        chk("rst_st_c3", 32'(state_dbg), 32'd0);
        chk("rst_ill", 32'(illegal), 32'd0);
        reset = 1'b0;
        #1;
        chk("fetch_ir", 32'(ir_write), 32'd1);
        chk("fetch_pc", 32'(pc_write), 32'd1);
        chk("fetch_srcb", 32'(alu_src_b), 32'd1);
        chk("fetch_rsrc", 32'(result_src), 32'd2);
        chk("fetch_ret", retired, 32'd0);

        // lw: 0,1,2,3,4,0
        step();
        chk("lw_s1", 32'(state_dbg), 32'd1);
        chk("lw_s1_srcb", 32'(alu_src_b), 32'd2);
        chk("lw_s1_rw", 32'(reg_write), 32'd0);
        step();
        chk("lw_s2", 32'(state_dbg), 32'd2);
        chk("lw_s2_srca", 32'(alu_src_a), 32'd1);
        chk("lw_s2_alu", 32'(alu_control), 32'd0);
        step();
        chk("lw_s3", 32'(state_dbg), 32'd3);
        chk("lw_s3_iod", 32'(instruction_or_data), 32'd1);
        chk("lw_s3_rw", 32'(reg_write), 32'd0);
        step();
        chk("lw_s4", 32'(state_dbg), 32'd4);
        chk("lw_s4_rw", 32'(reg_write), 32'd1);
        chk("lw_s4_rsrc", 32'(result_src), 32'd1);
        step();
        chk("lw_end", 32'(state_dbg), 32'd0);
        chk("lw_ret", retired, 32'd1);

        // sub then or
        instr = 32'h40208133;
        zero  = 1'b1;
        step();
        chk("sub_s1_pc", 32'(pc_write), 32'd0);
        step();
        chk("sub_s6", 32'(state_dbg), 32'd6);
        chk("sub_alu", 32'(alu_control), 32'b001);
        chk("sub_srcb", 32'(alu_src_b), 32'd0);
        step();
        chk("sub_s8", 32'(state_dbg), 32'd8);
        chk("sub_rw", 32'(reg_write), 32'd1);
        step();
        chk("sub_ret", retired, 32'd2);
        instr = 32'h0020E1B3;
        zero  = 1'b0;
        step();
        step();
        chk("or_s6", 32'(state_dbg), 32'd6);
        chk("or_alu", 32'(alu_control), 32'b011);
        step();
        chk("or_rw", 32'(reg_write), 32'd1);
        step();
        chk("or_end", 32'(state_dbg), 32'd0);
        chk("or_ret", retired, 32'd3);

        // beq taken, then not taken
        instr = 32'h00208463;
        zero  = 1'b1;
        step();
        step();
        chk("beqt_s9", 32'(state_dbg), 32'd9);
        chk("beqt_pc", 32'(pc_write), 32'd1);
        chk("beqt_alu", 32'(alu_control), 32'b001);
        step();
        chk("beqt_end", 32'(state_dbg), 32'd0);
        chk("beqt_ret", retired, 32'd4);
        zero = 1'b0;
        step();
        step();
        chk("beqn_s9", 32'(state_dbg), 32'd9);
        chk("beqn_pc", 32'(pc_write), 32'd0);
        step();
        chk("beqn_end", 32'(state_dbg), 32'd0);
        chk("beqn_ret", retired, 32'd5);

        // jal: 0,1,10,8,0
        instr = 32'h008000EF;
        step();
        step();
        chk("jal_s10", 32'(state_dbg), 32'd10);
        chk("jal_pc", 32'(pc_write), 32'd1);
        chk("jal_rw", 32'(reg_write), 32'd0);
        chk("jal_ret_mid", retired, 32'd5);
        step();
        chk("jal_s8", 32'(state_dbg), 32'd8);
        chk("jal_rw8", 32'(reg_write), 32'd1);
        chk("jal_pc8", 32'(pc_write), 32'd0);
        step();
        chk("jal_ret", retired, 32'd6);

        // sw: 0,1,2,5,0
        instr = 32'h00112223;
        step();
        step();
        step();
        chk("sw_s5", 32'(state_dbg), 32'd5);
        chk("sw_mw", 32'(mem_write), 32'd1);
        chk("sw_iod", 32'(instruction_or_data), 32'd1);
        step();
        chk("sw_ret", retired, 32'd7);

        // slti -> slt; addi with bit30 set stays add
        instr = 32'h0020A093;
        step();
        step();
        chk("slti_s7", 32'(state_dbg), 32'd7);
        chk("slti_alu", 32'(alu_control), 32'b101);
        step();
        step();
        instr = 32'h40008093;
        step();
        step();
        chk("addi_alu", 32'(alu_control), 32'b000);
        instr = 32'h0020F093;
        step();
        step();
        chk("addi_ret", retired, 32'd9);

        // andi: 0,1,7
        step();
        step();
        chk("andi_alu", 32'(alu_control), 32'b010);
        step();
        step();
        chk("andi_ret", retired, 32'd10);

        // illegal opcode
        instr = 32'h0000007F;
        step();
        chk("ill_dec", 32'(illegal), 32'd0);
        step();
        chk("ill_s11", 32'(state_dbg), 32'd11);
        chk("ill_set", 32'(illegal), 32'd1);
        for (int i = 0; i < 20; i++) begin
            zero = i[0];
            step();
            chk("ill_hold", {illegal, state_dbg, enables()}, {23'd0, 1'b1, 4'd11, 4'd0});
        end
        chk("ill_ret", retired, 32'd10);

        // reset mid-lw in MEMREAD
        reset = 1'b1;
        #1;
        chk("rst_clr_ill", 32'(illegal), 32'd0);
        step();
        reset = 1'b0;
        instr = 32'h00402083;
        step();
        step();
        step();
        chk("mid_s3", 32'(state_dbg), 32'd3);
        reset = 1'b1;
        #1;
        chk("mid_st", 32'(state_dbg), 32'd0);
        chk("mid_en", 32'(enables()), 32'h0);
        chk("mid_ret", retired, 32'd0);
        chk("mid_ill", 32'(illegal), 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("mid_fetch", 32'(ir_write), 32'd1);
        for (int i = 0; i < 5; i++) step();
        chk("mid_lw_end", 32'(state_dbg), 32'd0);
        chk("mid_lw_ret", retired, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
